// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared types and constants for the instruction memory loader
// Purpose: loader FSM state encoding plus stream framing constants.
// Ports: none (package).
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_CHECK,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream, control and memory write signals of the loader
// Purpose: bundles the loader's stream handshake, session control/status and memory write port.
// Ports (slave = loader view):
//   in : START, BYTE_IN[7:0], BYTE_VALID
//   out: BYTE_READY, MEM_WE, MEM_ADDR[31:0], MEM_WDATA[31:0], CORE_HOLD, BUSY, DONE, ERR
interface instr_mem_loader_if;

  logic        START;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        CORE_HOLD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  modport master (
    output START, BYTE_IN, BYTE_VALID,
    input  BYTE_READY, MEM_WE, MEM_ADDR, MEM_WDATA, CORE_HOLD, BUSY, DONE, ERR
  );

  modport slave (
    input  START, BYTE_IN, BYTE_VALID,
    output BYTE_READY, MEM_WE, MEM_ADDR, MEM_WDATA, CORE_HOLD, BUSY, DONE, ERR
  );

endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// rtl/instr_mem_loader_word_assembler.sv - big-endian byte-to-word shift register
// Purpose: shifts accepted bytes into a word, most significant byte first.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   shift_en         : shift byte_in into the word this cycle
//   clear            : zero the word and restart the byte index
//   byte_in[7:0]     : byte to shift in
//   word[31:0]       : assembled word (registered)
//   word_full        : the current shift completes a word
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [IDX_W-1:0] idx;

  // Flags the shift that brings in the last byte so the FSM can leave DATA on that same edge.
  assign word_full = shift_en && (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (shift_en) begin
      word <= {word[WORD_W-9:0], byte_in};
      idx  <= idx + 1'b1;  // wraps to 0 after the last byte of a word
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - length-prefixed byte stream loader for the instruction memory
// Purpose: takes a 16-bit word count then big-endian words, writes them to consecutive
//          word addresses from BASE_ADDR, and holds the core until the program is loaded.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_mem_loader_if.slave (START, byte stream, memory write, status)
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input logic               clk,
  input logic               rst_n,
  instr_mem_loader_if.slave bus
);

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH_WORDS);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       addr;
  logic              ready_q, we_q, hold_q, busy_q, done_q, err_q;
  logic              accept;
  logic              shift_en;
  logic              clear;
  logic              word_full;
  logic [WORD_W-1:0] word;

  // ready_q is itself a register, so there is no path from BYTE_VALID to BYTE_READY.
  assign accept   = bus.BYTE_VALID && ready_q;
  assign shift_en = (state == ST_DATA) && accept;
  assign clear    = (state == ST_CHECK);

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clear     (clear),
    .byte_in   (bus.BYTE_IN),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len       <= '0;
      remaining <= '0;
      addr      <= BASE_ADDR;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.START) begin
            state   <= ST_LEN_HI;
            addr    <= BASE_ADDR;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len[LEN_W-1 -: 8] <= bus.BYTE_IN;
            state             <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.BYTE_IN;
            state    <= ST_CHECK;
            ready_q  <= 1'b0;
          end
        end
        ST_CHECK: begin
          if ((len == '0) || ({1'b0, len} > DEPTH_L)) begin
            state  <= ST_ERROR;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            remaining <= len;
            state     <= ST_DATA;
            ready_q   <= 1'b1;
          end
        end
        ST_DATA: begin
          if (word_full) begin
            state   <= ST_WRITE;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
          end
        end
        ST_WRITE: begin
          we_q      <= 1'b0;
          addr      <= addr + 32'(BYTES_PER_WORD);
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            hold_q <= 1'b0;
            busy_q <= 1'b0;
          end else begin
            state   <= ST_DATA;
            ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.BYTE_READY = ready_q;
  assign bus.MEM_WE     = we_q;
  assign bus.MEM_ADDR   = addr;
  assign bus.MEM_WDATA  = word;  // the assembler register holds the finished word throughout WRITE
  assign bus.CORE_HOLD  = hold_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;

endmodule
